shift_reg_ctrl: RTL and testbench

- Parametrised successor to the 4-bit serial-in shift register.
- Generalises width and adds these features:
  - mode-selected shift left, shift right, rotate left, rotate right, parallel load and clear
  - clock enable
  - registered pattern-match pulse
  - saturating counter of consecutive all-zero cycles
- Standalone datapath block, driven directly by a testbench or a small control FSM.

---
 rtl/shift_reg_pkg.sv | 14 +
 rtl/sat_counter.sv | 25 ++
 rtl/shift_reg_ctrl.sv | 76 +++++++
 tb/tb_shift_reg_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - mode encodings shared by the shift register block and its users
package shift_reg_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_SHL  = 3'b001;
  localparam mode_t MODE_SHR  = 3'b010;
  localparam mode_t MODE_ROL  = 3'b011;
  localparam mode_t MODE_ROR  = 3'b100;
  localparam mode_t MODE_LOAD = 3'b101;
  localparam mode_t MODE_CLR  = 3'b110;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // clr wins over inc so a single-cycle break in a run always restarts the count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/shift_reg_ctrl.sv
// rtl/shift_reg_ctrl.sv - mode-selected shift/rotate/load register with match and zero-run tracking
module shift_reg_ctrl
  import shift_reg_pkg::*;
#(
  parameter int                 WIDTH   = 4,
  parameter int                 CNT_W   = 4,
  parameter logic [WIDTH-1:0]   PATTERN = WIDTH'(4'b1010)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             a,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             match,
  output logic             match_rise,
  output logic [CNT_W-1:0] zero_cnt
);

  logic [WIDTH-1:0] r_nx;
  logic             zero_nx;
  mode_t            mode_sel;

  assign mode_sel = mode;

  // Reserved encoding falls into the default arm and holds
  always_comb begin
    r_nx = r;
    if (en) begin
      case (mode_sel)
        MODE_HOLD: r_nx = r;
        MODE_SHL:  r_nx = {r[WIDTH-2:0], a};
        MODE_SHR:  r_nx = {a, r[WIDTH-1:1]};
        MODE_ROL:  r_nx = {r[WIDTH-2:0], r[WIDTH-1]};
        MODE_ROR:  r_nx = {r[0], r[WIDTH-1:1]};
        MODE_LOAD: r_nx = d;
        MODE_CLR:  r_nx = '0;
        default:   r_nx = r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r <= '0;
    end else begin
      r <= r_nx;
    end
  end

  // Rising edge of match is taken from r and r_nx so the pulse lines up with the new r
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_rise <= 1'b0;
    end else begin
      match_rise <= (r_nx == PATTERN) && (r != PATTERN);
    end
  end

  assign zero    = (r == '0);
  assign match   = (r == PATTERN);
  assign zero_nx = (r_nx == '0);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_zero_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (zero_nx),
    .clr   (!zero_nx),
    .cnt   (zero_cnt)
  );

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb/tb_shift_reg_ctrl.sv - directed bench with an arithmetic reference model for shift_reg_ctrl
module tb_shift_reg_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic       a;
  logic [3:0] d;
  logic [3:0] r;
  logic       zero;
  logic       match;
  logic       match_rise;
  logic [3:0] zero_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  int m_r    = 0;
  int m_cnt  = 0;
  bit m_rise = 1'b0;

  localparam int PAT = 10;

  shift_reg_ctrl #(
    .WIDTH   (4),
    .CNT_W   (4),
    .PATTERN (4'b1010)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .a          (a),
    .d          (d),
    .r          (r),
    .zero       (zero),
    .match      (match),
    .match_rise (match_rise),
    .zero_cnt   (zero_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register value treated as an integer 0..15
  function automatic int model_next(int cur, bit e, int md, int ain, int din);
    if (!e) return cur;
    case (md)
      1: return (cur * 2 + ain) % 16;
      2: return cur / 2 + ain * 8;
      3: return (cur * 2) % 16 + cur / 8;
      4: return cur / 2 + (cur % 2) * 8;
      5: return din;
      6: return 0;
      default: return cur;
    endcase
  endfunction

  always @(posedge clk) begin
    int nx;
    if (!rst_n) begin
      m_r    <= 0;
      m_rise <= 1'b0;
      m_cnt  <= 0;
    end else begin
      nx = model_next(m_r, en, int'(mode), int'(a), int'(d));
      m_rise <= (nx == PAT) && (m_r != PAT);
      m_cnt  <= (nx == 0) ? ((m_cnt + 1 > 15) ? 15 : m_cnt + 1) : 0;
      m_r    <= nx;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_r", r, m_r);
      check("model_zero", zero, (m_r == 0));
      check("model_match", match, (m_r == PAT));
      check("model_rise", match_rise, m_rise);
      check("model_cnt", zero_cnt, m_cnt);
    end
  end

  task automatic step(input logic rn, input logic e, input logic [2:0] m,
                      input logic aa, input logic [3:0] dd);
    rst_n = rn; en = e; mode = m; a = aa; d = dd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] shl_exp [4];
    logic [3:0] shr_exp [4];
    shl_exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    shr_exp = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};

    // reset with a load pending
    step(1'b0, 1'b1, 3'b101, 1'b0, 4'b1111);
    step(1'b0, 1'b1, 3'b101, 1'b0, 4'b1111);
    chk_on = 1'b1;
    check("rst_r", r, 4'b0000);
    check("rst_zero", zero, 1'b1);
    check("rst_match", match, 1'b0);
    check("rst_cnt", zero_cnt, 4'd0);
    check("rst_rise", match_rise, 1'b0);

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 3'b001, 1'b1, 4'b0000);
      check("shl_r", r, shl_exp[i]);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 3'b010, 1'b0, 4'b0000);
      check("shr_r", r, shr_exp[i]);
    end
    check("shr_zero", zero, 1'b1);
    check("shr_cnt", zero_cnt, 4'd1);

    // load then rotate into the pattern
    step(1'b1, 1'b1, 3'b101, 1'b0, 4'b0101);
    check("load_r", r, 4'b0101);
    check("load_cnt", zero_cnt, 4'd0);
    step(1'b1, 1'b1, 3'b011, 1'b0, 4'b0000);
    check("rol_r", r, 4'b1010);
    check("rol_match", match, 1'b1);
    check("rol_rise", match_rise, 1'b1);
    step(1'b1, 1'b1, 3'b000, 1'b0, 4'b0000);
    check("held_match", match, 1'b1);
    check("held_rise", match_rise, 1'b0);
    step(1'b1, 1'b1, 3'b011, 1'b1, 4'b0000);
    check("rol2_r", r, 4'b0101);
    check("rol2_match", match, 1'b0);
    step(1'b1, 1'b1, 3'b100, 1'b1, 4'b0000);
    check("ror_r", r, 4'b1010);
    check("ror_rise", match_rise, 1'b1);

    // zero run from a fresh reset, then saturation
    step(1'b0, 1'b1, 3'b000, 1'b0, 4'b0000);
    check("zr_cnt0", zero_cnt, 4'd0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1, 3'b000, 1'b0, 4'b0000);
      check("zr_cnt", zero_cnt, (i > 15) ? 4'd15 : 4'(i));
    end
    step(1'b1, 1'b1, 3'b101, 1'b0, 4'b0001);
    check("zr_load_r", r, 4'b0001);
    check("zr_load_cnt", zero_cnt, 4'd0);

    // enable low and reserved mode both hold
    step(1'b1, 1'b1, 3'b101, 1'b0, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 3'b001, 1'b1, 4'b1111);
      check("en0_r", r, 4'b0110);
    end
    step(1'b1, 1'b1, 3'b111, 1'b1, 4'b1111);
    check("rsvd_r", r, 4'b0110);
    check("rsvd_cnt", zero_cnt, 4'd0);

    // zero run keeps counting with en low
    step(1'b1, 1'b1, 3'b110, 1'b0, 4'b0000);
    check("clr_cnt", zero_cnt, 4'd1);
    step(1'b1, 1'b0, 3'b101, 1'b0, 4'b1111);
    step(1'b1, 1'b0, 3'b101, 1'b0, 4'b1111);
    check("en0_cnt", zero_cnt, 4'd3);
    check("en0_zero_r", r, 4'b0000);

    // reset in the middle of a shift sequence
    step(1'b1, 1'b1, 3'b001, 1'b1, 4'b0000);
    step(1'b1, 1'b1, 3'b001, 1'b1, 4'b0000);
    check("mid_pre_r", r, 4'b0011);
    step(1'b0, 1'b1, 3'b001, 1'b1, 4'b0000);
    check("mid_rst_r", r, 4'b0000);
    check("mid_rst_cnt", zero_cnt, 4'd0);
    step(1'b1, 1'b1, 3'b001, 1'b1, 4'b0000);
    check("mid_resume_r", r, 4'b0001);

    @(negedge clk);
    #1;
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
